// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - multi-line circular pixel delay buffer feeding the Sobel window generator
module sobel_line_buffer #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 128,
  parameter int NUM_LINES = 2
) (
  input  logic                            CLK,
  input  logic                            Reset,
  input  logic                            Enable,
  input  logic [DATA_W-1:0]               DataIn,
  output logic [(NUM_LINES+1)*DATA_W-1:0] TapOut,
  output logic                            ValidOut,
  output logic [$clog2(LINE_LEN)-1:0]     Col,
  output logic                            EndOfLine
);
  localparam int PTR_W    = $clog2(LINE_LEN);
  localparam int FILL_MAX = NUM_LINES * LINE_LEN;
  localparam int CNT_W    = $clog2(FILL_MAX + 1);
  localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(FILL_MAX);

  logic [PTR_W-1:0]                 wptr;
  logic [CNT_W-1:0]                 fillCnt;
  logic [NUM_LINES-1:0][DATA_W-1:0] stageIn;
  logic [NUM_LINES-1:0][DATA_W-1:0] stageRd;

  always_comb begin
    stageIn[0] = DataIn;
    for (int k = 1; k < NUM_LINES; k++) begin
      stageIn[k] = stageRd[k-1];
    end
  end

  // Each stage reads the old word at wptr and overwrites it with the previous stage's old word.
  for (genvar k = 0; k < NUM_LINES; k++) begin : gStage
    logic [DATA_W-1:0] mem [LINE_LEN];

    assign stageRd[k] = mem[wptr];

    always_ff @(posedge CLK) begin
      if (Enable && !Reset) begin
        mem[wptr] <= stageIn[k];
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wptr      <= '0;
      fillCnt   <= '0;
      TapOut    <= '0;
      ValidOut  <= 1'b0;
      Col       <= '0;
      EndOfLine <= 1'b0;
    end else if (Enable) begin
      TapOut[0 +: DATA_W] <= DataIn;
      // Memories are never cleared, so a stage stays masked until it has seen k full lines.
      for (int k = 1; k <= NUM_LINES; k++) begin
        TapOut[k*DATA_W +: DATA_W] <= (int'(fillCnt) >= k * LINE_LEN) ? stageRd[k-1] : '0;
      end
      ValidOut  <= (fillCnt == FILL_FULL);
      Col       <= wptr;
      EndOfLine <= (wptr == LAST_COL);
      wptr      <= (wptr == LAST_COL) ? '0 : wptr + 1'b1;
      if (fillCnt != FILL_FULL) begin
        fillCnt <= fillCnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb/tb_sobel_line_buffer.sv - randomized self-checking bench for sobel_line_buffer across four parameter sets
module tb_sobel_line_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst;
  logic [3:0]  en;
  logic [3:0]  valid;
  logic [3:0]  eol;
  logic [7:0]  dinA, dinB, dinC;
  logic [11:0] dinD;
  logic [23:0] tapA, tapB;
  logic [15:0] tapC;
  logic [35:0] tapD;
  logic [1:0]  colA, colD;
  logic [6:0]  colB;
  logic [2:0]  colC;

  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(4), .NUM_LINES(2)) dutA (
    .CLK(clk), .Reset(rst[0]), .Enable(en[0]), .DataIn(dinA),
    .TapOut(tapA), .ValidOut(valid[0]), .Col(colA), .EndOfLine(eol[0]));
  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(128), .NUM_LINES(2)) dutB (
    .CLK(clk), .Reset(rst[1]), .Enable(en[1]), .DataIn(dinB),
    .TapOut(tapB), .ValidOut(valid[1]), .Col(colB), .EndOfLine(eol[1]));
  sobel_line_buffer #(.DATA_W(8), .LINE_LEN(5), .NUM_LINES(1)) dutC (
    .CLK(clk), .Reset(rst[2]), .Enable(en[2]), .DataIn(dinC),
    .TapOut(tapC), .ValidOut(valid[2]), .Col(colC), .EndOfLine(eol[2]));
  sobel_line_buffer #(.DATA_W(12), .LINE_LEN(4), .NUM_LINES(2)) dutD (
    .CLK(clk), .Reset(rst[3]), .Enable(en[3]), .DataIn(dinD),
    .TapOut(tapD), .ValidOut(valid[3]), .Col(colD), .EndOfLine(eol[3]));

  // Reference model: per-instance history of accepted pixels; outputs derived from pixel index.
  int lineLen  [4] = '{4, 128, 5, 4};
  int numLines [4] = '{2, 2, 1, 2};
  int dataW    [4] = '{8, 8, 8, 12};
  int hist     [4][$];
  int expTap   [4][3];
  int expValid [4];
  int expCol   [4];
  int expEol   [4];
  int nAsserts = 0;
  int nFails   = 0;

  function automatic int obsTap(int d, int k);
    case (d)
      0:       return int'(tapA[k*8 +: 8]);
      1:       return int'(tapB[k*8 +: 8]);
      2:       return int'(tapC[k*8 +: 8]);
      default: return int'(tapD[k*12 +: 12]);
    endcase
  endfunction

  function automatic int obsCol(int d);
    case (d)
      0:       return int'(colA);
      1:       return int'(colB);
      2:       return int'(colC);
      default: return int'(colD);
    endcase
  endfunction

  task automatic check(string tag, int obs, int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(int d, string tag);
    for (int k = 0; k <= numLines[d]; k++) begin
      check($sformatf("%s dut%0d tap%0d", tag, d, k), obsTap(d, k), expTap[d][k]);
    end
    check($sformatf("%s dut%0d valid", tag, d), int'(valid[d]), expValid[d]);
    check($sformatf("%s dut%0d col", tag, d), obsCol(d), expCol[d]);
    check($sformatf("%s dut%0d eol", tag, d), int'(eol[d]), expEol[d]);
  endtask

  task automatic modelClear(int d);
    hist[d].delete();
    for (int k = 0; k < 3; k++) expTap[d][k] = 0;
    expValid[d] = 0;
    expCol[d]   = 0;
    expEol[d]   = 0;
  endtask

  // Async reset pulse placed between clock edges; outputs must clear without waiting for an edge.
  task automatic resetDut(int d);
    rst[d] = 1'b1;
    #2;
    modelClear(d);
    checkAll(d, "reset");
    rst[d] = 1'b0;
  endtask

  task automatic step(int d, bit e, int px);
    int mask;
    int n;
    int l;
    mask = (1 << dataW[d]) - 1;
    case (d)
      0:       dinA = 8'(px);
      1:       dinB = 8'(px);
      2:       dinC = 8'(px);
      default: dinD = 12'(px);
    endcase
    en[d] = e;
    @(posedge clk);
    #1;
    en[d] = 1'b0;
    if (e) begin
      l = lineLen[d];
      n = hist[d].size();
      hist[d].push_back(px & mask);
      expTap[d][0] = px & mask;
      for (int k = 1; k <= numLines[d]; k++) begin
        expTap[d][k] = (n >= k * l) ? hist[d][n - k*l] : 0;
      end
      expValid[d] = (n >= numLines[d] * l) ? 1 : 0;
      expCol[d]   = n % l;
      expEol[d]   = (n % l == l - 1) ? 1 : 0;
    end
    checkAll(d, e ? "accept" : "hold");
  endtask

  task automatic rampA(int count);
    for (int i = 0; i < count; i++) begin
      step(0, 1'b1, i + 1);
      if (i == 3) check("s1 n3 tap0", obsTap(0, 0), 4);
      if (i == 4) begin
        check("s1 n4 tap1", obsTap(0, 1), 1);
        check("s1 n4 valid", int'(valid[0]), 0);
      end
      if (i == 8) begin
        check("s1 n8 tap2", obsTap(0, 2), 1);
        check("s1 n8 tap1", obsTap(0, 1), 5);
        check("s1 n8 valid", int'(valid[0]), 1);
      end
    end
  endtask

  task automatic finalA(string tag);
    check({tag, " tap0"}, obsTap(0, 0), 16);
    check({tag, " tap1"}, obsTap(0, 1), 12);
    check({tag, " tap2"}, obsTap(0, 2), 8);
    check({tag, " col"}, obsCol(0), 3);
    check({tag, " eol"}, int'(eol[0]), 1);
  endtask

  initial begin
    int accepted;
    int gap;
    rst  = '0;
    en   = '0;
    dinA = '0;
    dinB = '0;
    dinC = '0;
    dinD = '0;
    for (int d = 0; d < 4; d++) resetDut(d);

    // Fill and steady state
    rampA(16);
    finalA("s1 final");

    // Mid-line async reset, then the ramp must replay identically
    resetDut(0);
    rampA(10);
    resetDut(0);
    rampA(16);
    finalA("s4 final");

    // Enable gaps 1,0,0 with random junk on the data bus during idle cycles
    resetDut(0);
    accepted = 0;
    gap = 0;
    while (accepted < 16) begin
      if (gap == 0) begin
        step(0, 1'b1, accepted + 1);
        accepted++;
      end else begin
        step(0, 1'b0, int'($urandom_range(0, 255)));
      end
      gap = (gap + 1) % 3;
    end
    finalA("s2 final");

    // Default geometry
    for (int i = 0; i < 512; i++) begin
      step(1, 1'b1, i % 256);
      if (i == 255) check("s3 n255 valid", int'(valid[1]), 0);
      if (i == 256) check("s3 n256 valid", int'(valid[1]), 1);
      if (i == 300) begin
        check("s3 n300 tap0", obsTap(1, 0), 44);
        check("s3 n300 tap1", obsTap(1, 1), 172);
        check("s3 n300 tap2", obsTap(1, 2), 44);
        check("s3 n300 col", obsCol(1), 44);
      end
    end

    // Non-power-of-2 line length with random pixels
    for (int i = 0; i < 12; i++) begin
      step(2, 1'b1, int'($urandom_range(0, 255)));
      if (i == 4 || i == 9) check($sformatf("s5 n%0d eol", i), int'(eol[2]), 1);
      if (i == 5) check("s5 n5 col", obsCol(2), 0);
      if (i == 7) check("s5 n7 tap1", obsTap(2, 1), hist[2][2]);
    end

    // Wide data, random gaps, well past fill saturation
    step(3, 1'b1, 12'hFFF);
    check("s6 first tap0", obsTap(3, 0), 4095);
    step(3, 1'b1, 12'hABC);
    check("s6 second tap0", obsTap(3, 0), 2748);
    accepted = 2;
    while (accepted < 90) begin
      if ($urandom_range(0, 3) != 0) begin
        step(3, 1'b1, int'($urandom_range(0, 4095)));
        accepted++;
      end else begin
        step(3, 1'b0, int'($urandom_range(0, 4095)));
      end
    end
    check("s6 valid held", int'(valid[3]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
